// File: rtl/mod_counter_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mod_counter_if : control, data and display signals of one counter stage   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface mod_counter_if #(
   parameter int WIDTH = 6
);
   logic             load;
   logic [WIDTH-1:0] data;
   logic             cnt_in;
   logic             down;
   logic [WIDTH-1:0] max_in;
   logic             enable;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] databus;
   logic             cnt_out;
   logic             load_err;

   modport master (
      output load, data, cnt_in, down, max_in, enable,
      input  count, databus, cnt_out, load_err
   );

   modport slave (
      input  load, data, cnt_in, down, max_in, enable,
      output count, databus, cnt_out, load_err
   );
endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mod_counter : cascadable up/down modulo counter with runtime upper limit  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module mod_counter #(
   parameter int WIDTH     = 6,
   parameter int MIN_VAL   = 0,
   parameter int MAX_VAL   = 59,
   parameter int RESET_VAL = MIN_VAL
) (
   input  wire logic     clk,
   input  wire logic     clear_n,
   mod_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_min   = WIDTH'(MIN_VAL);
   localparam logic [WIDTH-1:0] c_max   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_q, count_d;
   logic             load_err_q, load_err_d;

   logic             w_max_ge_min;
   logic             w_data_ge_min;
   logic [WIDTH-1:0] w_lim;
   logic             w_data_ok;
   logic             w_at_min;
   logic             w_at_top;
   logic             w_term;

   // A zero floor makes the lower-bound compares trivially true.
   generate
      if (MIN_VAL == 0) begin : g_min_zero
         assign w_max_ge_min  = 1'b1;
         assign w_data_ge_min = 1'b1;
      end else begin : g_min_nonzero
         assign w_max_ge_min  = (bus.max_in >= c_min);
         assign w_data_ge_min = (bus.data >= c_min);
      end
   endgenerate

   assign w_lim     = (w_max_ge_min && (bus.max_in <= c_max)) ? bus.max_in : c_max;
   assign w_data_ok = w_data_ge_min && (bus.data <= w_lim);
   assign w_at_min  = (count_q == c_min);
   assign w_at_top  = (count_q >= w_lim);
   assign w_term    = bus.down ? w_at_min : w_at_top;

   always_comb begin
      count_d    = count_q;
      load_err_d = 1'b0;
      if (bus.load) begin
         if (w_data_ok) begin
            count_d = bus.data;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (bus.cnt_in) begin
         if (!bus.down) begin
            count_d = w_at_top ? c_min : count_q + WIDTH'(1);
         end else if (w_at_min || (count_q > w_lim)) begin
            count_d = w_lim;
         end else begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         count_q    <= c_reset;
         load_err_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         load_err_q <= load_err_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.databus  = {WIDTH{bus.enable}} & count_q;
   assign bus.cnt_out  = bus.cnt_in & ~bus.load & clear_n & w_term;
   assign bus.load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mod_counter : scoreboard bench for a sec/min cascade and a day stage   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_mod_counter;

   logic clk = 1'b0;
   logic clear_n;
   always #5 clk = ~clk;

   mod_counter_if #(.WIDTH(6)) sec_if ();
   mod_counter_if #(.WIDTH(6)) min_if ();
   mod_counter_if #(.WIDTH(6)) day_if ();

   mod_counter #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0))
      u_sec (.clk(clk), .clear_n(clear_n), .bus(sec_if.slave));
   mod_counter #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(0))
      u_min (.clk(clk), .clear_n(clear_n), .bus(min_if.slave));
   mod_counter #(.WIDTH(6), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1))
      u_day (.clk(clk), .clear_n(clear_n), .bus(day_if.slave));

   assign min_if.cnt_in = sec_if.cnt_out;

   typedef struct {
      string      name;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   passes = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_n = 1'b0;
      sec_if.load = 1'b0; sec_if.data = 6'd0; sec_if.cnt_in = 1'b1;
      sec_if.down = 1'b0; sec_if.max_in = 6'd59; sec_if.enable = 1'b1;
      min_if.load = 1'b0; min_if.data = 6'd0; min_if.down = 1'b0;
      min_if.max_in = 6'd59; min_if.enable = 1'b1;
      day_if.load = 1'b0; day_if.data = 6'd0; day_if.cnt_in = 1'b0;
      day_if.down = 1'b0; day_if.max_in = 6'd31; day_if.enable = 1'b1;
      tick(); tick();
      sb.push_back('{"rst_count", 6'd0});
      sb.push_back('{"rst_load_err", 6'd0});
      sb.push_back('{"rst_cnt_out", 6'd0});
      sb.push_back('{"rst_day_count", 6'd1});
      e = sb.pop_front(); checks++;
      if (sec_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.count, e.val); else passes++;
      e = sb.pop_front(); checks++;
      if ({5'd0, sec_if.load_err} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.load_err, e.val); else passes++;
      e = sb.pop_front(); checks++;
      if ({5'd0, sec_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.cnt_out, e.val); else passes++;
      e = sb.pop_front(); checks++;
      if (day_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.count, e.val); else passes++;
      clear_n = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         sb.push_back('{"release_count", 6'(k)});
         sb.push_back('{"release_databus", 6'(k)});
         tick();
         e = sb.pop_front(); checks++;
         if (sec_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.count, e.val); else passes++;
         e = sb.pop_front(); checks++;
         if (sec_if.databus !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.databus, e.val); else passes++;
      end
      // Reset outranks a simultaneous load.
      clear_n = 1'b0; sec_if.load = 1'b1; sec_if.data = 6'd30;
      #1;
      sb.push_back('{"rst_mid_cnt_out", 6'd0});
      e = sb.pop_front(); checks++;
      if ({5'd0, sec_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.cnt_out, e.val); else passes++;
      sb.push_back('{"rst_mid_count", 6'd0});
      tick();
      e = sb.pop_front(); checks++;
      if (sec_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.count, e.val); else passes++;
      clear_n = 1'b1; sec_if.load = 1'b0;
   endtask

   task automatic test_up_wrap();
      sec_if.cnt_in = 1'b0; sec_if.load = 1'b1; sec_if.data = 6'd58;
      tick();
      sec_if.load = 1'b0; sec_if.cnt_in = 1'b1; sec_if.enable = 1'b0;
      #1;
      sb.push_back('{"upwrap_count", 6'd58}); sb.push_back('{"upwrap_cnt_out", 6'd0});
      sb.push_back('{"upwrap_count", 6'd59}); sb.push_back('{"upwrap_cnt_out", 6'd1});
      sb.push_back('{"upwrap_count", 6'd0});  sb.push_back('{"upwrap_cnt_out", 6'd0});
      for (int k = 0; k < 3; k++) begin
         e = sb.pop_front(); checks++;
         if (sec_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.count, e.val); else passes++;
         e = sb.pop_front(); checks++;
         if ({5'd0, sec_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, sec_if.cnt_out, e.val); else passes++;
         checks++;
         if (sec_if.databus !== 6'd0) $display("FAIL upwrap_databus_off: got %0d want 0", sec_if.databus); else passes++;
         if (k < 2) tick();
      end
      sec_if.cnt_in = 1'b0; sec_if.enable = 1'b1;
   endtask

   task automatic test_down_wrap();
      day_if.max_in = 6'd28; day_if.load = 1'b1; day_if.data = 6'd1; day_if.cnt_in = 1'b0;
      tick();
      day_if.load = 1'b0; day_if.down = 1'b1; day_if.cnt_in = 1'b1;
      #1;
      sb.push_back('{"downwrap_cnt_out_pre", 6'd1});
      e = sb.pop_front(); checks++;
      if ({5'd0, day_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.cnt_out, e.val); else passes++;
      sb.push_back('{"downwrap_count", 6'd28});
      sb.push_back('{"downwrap_count_next", 6'd27});
      tick();
      e = sb.pop_front(); checks++;
      if (day_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.count, e.val); else passes++;
      tick();
      e = sb.pop_front(); checks++;
      if (day_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.count, e.val); else passes++;
      day_if.cnt_in = 1'b0; day_if.down = 1'b0;
   endtask

   task automatic test_limit_shrink();
      for (int dn = 0; dn < 2; dn++) begin
         day_if.max_in = 6'd31; day_if.load = 1'b1; day_if.data = 6'd31; day_if.cnt_in = 1'b0;
         tick();
         day_if.load = 1'b0; day_if.max_in = 6'd30; day_if.down = (dn == 1); day_if.cnt_in = 1'b1;
         #1;
         sb.push_back('{dn ? "shrink_dn_cnt_out" : "shrink_up_cnt_out", dn ? 6'd0 : 6'd1});
         sb.push_back('{dn ? "shrink_dn_count" : "shrink_up_count", dn ? 6'd30 : 6'd1});
         e = sb.pop_front(); checks++;
         if ({5'd0, day_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.cnt_out, e.val); else passes++;
         tick();
         e = sb.pop_front(); checks++;
         if (day_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.count, e.val); else passes++;
         day_if.cnt_in = 1'b0; day_if.down = 1'b0;
      end
   endtask

   task automatic test_load();
      logic [5:0] dv [5] = '{6'd7, 6'd0, 6'd13, 6'd12, 6'd5};
      logic [5:0] ec [5] = '{6'd7, 6'd7, 6'd7, 6'd12, 6'd5};
      logic [5:0] ee [5] = '{6'd0, 6'd1, 6'd1, 6'd0, 6'd0};
      day_if.max_in = 6'd12; day_if.down = 1'b0;
      day_if.load = 1'b1; day_if.data = 6'd3; day_if.cnt_in = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         day_if.load = 1'b1; day_if.data = dv[k]; day_if.cnt_in = 1'b1;
         #1;
         // Load at the limit with cnt_in high must still suppress the carry.
         if (k == 4) begin
            sb.push_back('{"load_blocks_cnt_out", 6'd0});
            e = sb.pop_front(); checks++;
            if ({5'd0, day_if.cnt_out} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.cnt_out, e.val); else passes++;
         end
         sb.push_back('{"load_count", ec[k]});
         sb.push_back('{"load_err", ee[k]});
         tick();
         e = sb.pop_front(); checks++;
         if (day_if.count !== e.val) $display("FAIL %s[%0d]: got %0d want %0d", e.name, k, day_if.count, e.val); else passes++;
         e = sb.pop_front(); checks++;
         if ({5'd0, day_if.load_err} !== e.val) $display("FAIL %s[%0d]: got %0d want %0d", e.name, k, day_if.load_err, e.val); else passes++;
      end
      // Out-of-range max_in falls back to MAX_VAL=31 in both directions.
      for (int k = 0; k < 2; k++) begin
         day_if.max_in = (k == 0) ? 6'd40 : 6'd0;
         day_if.load = 1'b1; day_if.data = 6'd31 - 6'(k); day_if.cnt_in = 1'b0;
         sb.push_back('{"badlim_count", 6'd31 - 6'(k)});
         sb.push_back('{"badlim_err", 6'd0});
         tick();
         e = sb.pop_front(); checks++;
         if (day_if.count !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.count, e.val); else passes++;
         e = sb.pop_front(); checks++;
         if ({5'd0, day_if.load_err} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.load_err, e.val); else passes++;
      end
      day_if.load = 1'b0; day_if.max_in = 6'd31;
      sb.push_back('{"load_err_clears", 6'd0});
      tick();
      e = sb.pop_front(); checks++;
      if ({5'd0, day_if.load_err} !== e.val) $display("FAIL %s: got %0d want %0d", e.name, day_if.load_err, e.val); else passes++;
   endtask

   task automatic test_cascade();
      int pulses = 0;
      clear_n = 1'b0; sec_if.load = 1'b0; sec_if.down = 1'b0; sec_if.cnt_in = 1'b1;
      tick();
      clear_n = 1'b1;
      #1;
      for (int k = 0; k < 3600; k++) begin
         if (min_if.cnt_out === 1'b1) pulses++;
         sb.push_back('{"cascade_sec", 6'((k + 1) % 60)});
         sb.push_back('{"cascade_min", 6'(((k + 1) / 60) % 60)});
         tick();
         e = sb.pop_front(); checks++;
         if (sec_if.count !== e.val) $display("FAIL %s@%0d: got %0d want %0d", e.name, k, sec_if.count, e.val); else passes++;
         e = sb.pop_front(); checks++;
         if (min_if.count !== e.val) $display("FAIL %s@%0d: got %0d want %0d", e.name, k, min_if.count, e.val); else passes++;
      end
      checks++;
      if (pulses !== 1) $display("FAIL cascade_min_cnt_out_pulses: got %0d want 1", pulses); else passes++;
      sec_if.cnt_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_limit_shrink();
      test_load();
      test_cascade();
      checks++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drained: got %0d want 0", sb.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter that generalises the clock's seconds/minutes/hours stages and the calendar's day/month stages into one block. It counts between a configurable minimum and a runtime-adjustable maximum, steps only when its carry-in is asserted, counts up or down, and accepts range-checked parallel loads. It drives a shared display bus and produces a same-cycle carry-out, so instances cascade into a chain: sec → min → hour → day → month.

## Interface
Parameters:
- WIDTH, 6, bit width of the count, data, limit and bus.
- MIN_VAL, 0, lowest count value. Use 1 for day and month stages.
- MAX_VAL, 59, highest legal count value; static upper bound.
- RESET_VAL, MIN_VAL, value loaded on reset. Must lie in [MIN_VAL, MAX_VAL].

Ports:
- clk, input, 1, rising-edge clock.
- clear_n, input, 1, synchronous active-low reset.
- load, input, 1, parallel load request.
- data, input, WIDTH, load value.
- cnt_in, input, 1, step enable (carry from the previous stage). Tie high for a free-running stage.
- down, input, 1, 0 = count up, 1 = count down.
- max_in, input, WIDTH, runtime upper limit, e.g. month length. Tie to MAX_VAL if unused.
- enable, input, 1, bus drive enable.
- count, output, WIDTH, current registered count.
- databus, output, WIDTH, count when enable=1, else all zeros.
- cnt_out, output, 1, carry/borrow to the next stage (combinational).
- load_err, output, 1, one-cycle pulse flagging a rejected load.

## Operation
- Effective limit: lim = max_in if MIN_VAL ≤ max_in ≤ MAX_VAL, else MAX_VAL. lim is evaluated combinationally every cycle.
- Priority at each rising edge: clear_n=0, then load, then step (cnt_in=1), then hold.
- Reset (clear_n=0): count ← RESET_VAL and load_err ← 0. load and cnt_in are ignored.
- Load:
  - If MIN_VAL ≤ data ≤ lim: count ← data.
  - Otherwise: count holds and load_err=1 for the next cycle only.
  - A load in the same cycle as cnt_in wins, and no step occurs.
- Step up (cnt_in=1, down=0):
  - If count ≥ lim: count ← MIN_VAL (wrap). The ≥ covers the case where lim has dropped below count, e.g. day 31 followed by a switch to a 30-day month.
  - Otherwise: count ← count+1.
- Step down (cnt_in=1, down=1):
  - If count = MIN_VAL: count ← lim (wrap).
  - If count > lim: count ← lim.
  - Otherwise: count ← count−1.
- cnt_out = cnt_in & ~load & clear_n & term.
  - term = (count ≥ lim) when down=0.
  - term = (count = MIN_VAL) when down=1.
  - cnt_out is high exactly in cycles where this stage wraps.
  - The clamp from count > lim on a down-step does not assert cnt_out.
- databus = {WIDTH{enable}} & count, purely combinational.
- Arithmetic: unsigned WIDTH bits. Values never leave [MIN_VAL, MAX_VAL] except transiently when count > lim after lim shrinks; the next step or load corrects this.

## Timing
- count updates one clock after the qualifying edge inputs; there is no other latency.
- cnt_out and databus are combinational from registered count plus the cnt_in/load/down/enable/max_in inputs. A chain of N stages therefore ripples within one cycle.
- load_err is registered and lasts exactly one cycle per rejected load. Back-to-back bad loads keep it high.
- Reset mid-count takes effect at the next edge regardless of other inputs. cnt_out is low while clear_n=0.
- No handshake. Inputs are sampled every edge and the block has no stall.

## Test plan
- Reset: clear_n=0 with cnt_in=1 for 2 cycles (RESET_VAL=0) → count=0, load_err=0, cnt_out=0. Release → count increments 0,1,2.
- Up wrap (MAX_VAL=59): cnt_in=1 held → sequence 58,59,0. cnt_out=1 only in the cycle count=59. With enable=0, databus=0 throughout.
- Down wrap (MIN_VAL=1, MAX_VAL=31, max_in=28, down=1): from count=1, one step → count=28 with cnt_out=1. Next step → 27.
- Limit shrink: count=31, max_in changed to 30, one up-step → count=1 with cnt_out=1. Down-step from 31 with max_in=30 → count=30 with cnt_out=0.
- Load checks (MIN 1, lim 12):
  - data=7 with cnt_in=1 → count=7, no step.
  - data=0 → count unchanged, load_err=1 for one cycle.
  - data=13 → same rejection.
- Cascade of two instances (60 × 60), first stage's cnt_in=1: after 3600 cycles both counts return to 0. Stage-2 cnt_out pulses once per 3600 cycles.
